led_animator: RTL and testbench
===============================

LED_ANIMATOR -- requirements
Module: led_animator

Interface
REQ-001 The block SHALL have exactly one clock, i_clk, and its reset SHALL be asynchronous and active-low, named i_rst_n.
REQ-002 Parameter POS_W, default 3: width of each position field (guess, mole).
REQ-003 Parameter STAT_W, default 2: width of the status/animation field.
REQ-004 Parameter PHASE_CYCLES, default 20_000_000: clocks per blink phase (must be >= 2).
REQ-005 Parameter N_BLINKS, default 3: number of on-phases in the correct-guess animation (must be >= 1).
REQ-006 Parameter GO_CYCLES, default 25_000_000: clocks per half-period of the game-over flash (must be >= 2).
REQ-007 Port list SHALL be:
  i_clk  in  1  system clock
  i_rst_n  in  1  async active-low reset
  i_restart_game  in  1  synchronous clear, one cycle or held
  i_user_guess  in  POS_W  current guess position
  i_mole_position  in  POS_W  current mole position
  i_user_right  in  1  single-cycle pulse: correct guess
  i_user_wrong  in  1  single-cycle pulse: wrong guess
  i_game_over  in  1  single-cycle pulse or level: game ended
  leds  out  2*POS_W+STAT_W  registered LED drive
  o_anim_busy  out  1  high while state != IDLE

Function
REQ-008 leds field map SHALL be: [POS_W-1:0] = guess, [2*POS_W-1:POS_W] = mole, [MSB:2*POS_W] = status.
REQ-009 All outputs SHALL be registered, with 1-cycle latency from any input to leds.
REQ-010 The FSM SHALL have states IDLE, BLINK, SOLID, GAME_OVER.
REQ-011 Event priority SHALL be, per cycle: i_restart_game > i_game_over > i_user_right > i_user_wrong.
REQ-012 IDLE: status = 0; guess and mole fields follow the inputs.
REQ-013 i_user_right SHALL enter BLINK, with phase index 0 and phase counter 0.
REQ-014 BLINK SHALL run 2*N_BLINKS-1 phases of PHASE_CYCLES each.
REQ-015 In BLINK, status SHALL be all ones on even phases and 0 on odd phases; after the last phase, state SHALL go to IDLE.
REQ-016 i_user_wrong SHALL enter SOLID, with status all ones for (2*N_BLINKS-1)*PHASE_CYCLES cycles, then IDLE.
REQ-017 A right/wrong event arriving in BLINK or SOLID SHALL retrigger: switch to the new state and restart all counters from 0.
REQ-018 i_game_over SHALL enter GAME_OVER from any state.
REQ-019 In GAME_OVER, all leds bits SHALL toggle together (all ones, then all zeros) every GO_CYCLES, starting all ones.
REQ-020 In GAME_OVER, i_user_right and i_user_wrong SHALL be ignored; only restart or reset exits.
REQ-021 i_restart_game SHALL, on the next edge, set state IDLE, zero all counters, and set leds = 0 for that cycle.
REQ-022 Counter widths SHALL be $clog2 of the respective terminal count plus 1; counters SHALL saturate, never wrap.
REQ-023 o_anim_busy SHALL be 1 in BLINK, SOLID and GAME_OVER, and 0 in IDLE.

Reset
REQ-024 While i_rst_n = 0: state = IDLE, all counters = 0, leds = 0, o_anim_busy = 0, asynchronously.
REQ-025 Reset deassertion SHALL be synchronised externally; the block SHALL resume IDLE behaviour on the first edge after release.

Structure
REQ-026 Package led_anim_pkg SHALL hold the state encoding (2-bit: IDLE=0, BLINK=1, SOLID=2, GAME_OVER=3) and the field-offset localparams.
REQ-027 Sub-module phase_timer SHALL provide a parametrised saturating up-counter with clear input and a terminal-count pulse; it SHALL be instantiated for the phase timer and the game-over timer.

Verification (bench parameters: POS_W=3, STAT_W=2, PHASE_CYCLES=4, N_BLINKS=3, GO_CYCLES=3)
REQ-028 Scenario: guess=3'b101, mole=3'b010, no events -> leds=8'b00_010_101 one cycle later; o_anim_busy=0.
REQ-029 Scenario: right pulse -> status sequence 11 x4, 00 x4, 11 x4, 00 x4, 11 x4, then 00 and IDLE; o_anim_busy high for exactly 20 cycles.
REQ-030 Scenario: wrong pulse, then right pulse 6 cycles later -> status 11 for 6 cycles, then a full 20-cycle blink sequence from phase 0.
REQ-031 Scenario: game_over pulse during BLINK -> leds=8'hFF x3, 8'h00 x3, repeating; later right/wrong pulses cause no change.
REQ-032 Scenario: restart and right asserted in the same cycle -> leds=0 and IDLE next cycle; no animation follows.
REQ-033 Scenario: i_rst_n dropped mid-SOLID -> leds=0 immediately (no clock edge needed); IDLE after release.

Source files
------------

// File: rtl/led_anim_pkg.sv
// led_anim_pkg -- shared encodings for the LED animator.
// Holds the 2-bit FSM state encoding and the bit offsets of the guess, mole
// and status fields inside the leds vector.
package led_anim_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BLINK     = 2'd1;
    localparam logic [1:0] ST_SOLID     = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    localparam int GUESS_LSB = 0;

    // The mole field sits directly above the guess field.
    function automatic int mole_lsb(input int pos_w);
        return pos_w;
    endfunction

    // The status field sits above both position fields.
    function automatic int stat_lsb(input int pos_w);
        return 2 * pos_w;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer -- saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : forces the count back to 0 (wins over enable)
//   enable     : advance the count by one per cycle
//   tc         : high while enabled and the count sits at TERM_COUNT-1
// The count holds at TERM_COUNT-1 instead of wrapping; the owner clears it.
module phase_timer #(
    parameter int TERM_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = $clog2(TERM_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM_COUNT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = enable && (count == LAST);

endmodule

// File: rtl/led_animator.sv
// led_animator -- drives the whack-a-mole LED bank.
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_restart_game   : synchronous clear back to IDLE with leds dark
//   i_user_guess     : guess position shown in the low field
//   i_mole_position  : mole position shown in the middle field
//   i_user_right     : pulse, starts the blink animation
//   i_user_wrong     : pulse, starts the solid animation
//   i_game_over      : pulse or level, starts the game-over flash
//   leds             : {status, mole, guess}, registered
//   o_anim_busy      : high whenever the FSM is not IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | status dark, position fields follow the inputs
// BLINK     | 2*N_BLINKS-1 phases, status lit on even phases
// SOLID     | status lit for the same total length as BLINK
// GAME_OVER | every led bit flashes together, only restart/reset exits
module led_animator
    import led_anim_pkg::*;
#(
    parameter int POS_W        = 3,
    parameter int STAT_W       = 2,
    parameter int PHASE_CYCLES = 20_000_000,
    parameter int N_BLINKS     = 3,
    parameter int GO_CYCLES    = 25_000_000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_restart_game,
    input  logic [POS_W-1:0]          i_user_guess,
    input  logic [POS_W-1:0]          i_mole_position,
    input  logic                      i_user_right,
    input  logic                      i_user_wrong,
    input  logic                      i_game_over,
    output logic [2*POS_W+STAT_W-1:0] leds,
    output logic                      o_anim_busy
);

    localparam int LED_W    = 2 * POS_W + STAT_W;
    localparam int N_PHASES = 2 * N_BLINKS - 1;
    localparam int PH_W     = $clog2(N_PHASES) + 1;
    localparam int MOLE_LSB = mole_lsb(POS_W);
    localparam int STAT_LSB = stat_lsb(POS_W);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASES - 1);

    logic [1:0]       state, state_nxt;
    logic [PH_W-1:0]  phase_idx, phase_nxt;
    logic             go_lvl, go_lvl_nxt;
    logic [STAT_W-1:0] status_nxt;
    logic [LED_W-1:0] leds_nxt;

    logic ph_clr, ph_en, ph_tc;
    logic go_clr, go_en, go_tc;

    assign ph_en = (state == ST_BLINK) || (state == ST_SOLID);
    assign go_en = (state == ST_GAME_OVER);
    // Outside GAME_OVER the flash timer is held at 0 so entry always starts fresh.
    assign go_clr = i_restart_game || !go_en || go_tc;

    phase_timer #(.TERM_COUNT(PHASE_CYCLES)) u_phase_timer (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (ph_clr),
        .enable (ph_en),
        .tc     (ph_tc)
    );

    phase_timer #(.TERM_COUNT(GO_CYCLES)) u_go_timer (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (go_clr),
        .enable (go_en),
        .tc     (go_tc)
    );

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_idx;
        go_lvl_nxt = go_lvl;
        ph_clr     = 1'b0;
        if (i_restart_game) begin
            state_nxt  = ST_IDLE;
            phase_nxt  = '0;
            go_lvl_nxt = 1'b0;
            ph_clr     = 1'b1;
        end else if (i_game_over && (state != ST_GAME_OVER)) begin
            state_nxt  = ST_GAME_OVER;
            phase_nxt  = '0;
            go_lvl_nxt = 1'b1;
            ph_clr     = 1'b1;
        end else if (state == ST_GAME_OVER) begin
            // A held game_over level lands here too, so the flash keeps running.
            if (go_tc) begin
                go_lvl_nxt = ~go_lvl;
            end
        end else if (i_user_right) begin
            state_nxt = ST_BLINK;
            phase_nxt = '0;
            ph_clr    = 1'b1;
        end else if (i_user_wrong) begin
            state_nxt = ST_SOLID;
            phase_nxt = '0;
            ph_clr    = 1'b1;
        end else if (ph_tc) begin
            ph_clr = 1'b1;
            if (phase_idx == PH_LAST) begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end else begin
                phase_nxt = phase_idx + 1'b1;
            end
        end
    end

    always_comb begin
        status_nxt = '0;
        case (state_nxt)
            ST_BLINK: status_nxt = phase_nxt[0] ? '0 : '1;
            ST_SOLID: status_nxt = '1;
            default:  status_nxt = '0;
        endcase
    end

    always_comb begin
        leds_nxt = '0;
        if (i_restart_game) begin
            leds_nxt = '0;
        end else if (state_nxt == ST_GAME_OVER) begin
            leds_nxt = {LED_W{go_lvl_nxt}};
        end else begin
            leds_nxt[GUESS_LSB +: POS_W] = i_user_guess;
            leds_nxt[MOLE_LSB +: POS_W]  = i_mole_position;
            leds_nxt[STAT_LSB +: STAT_W] = status_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            phase_idx   <= '0;
            go_lvl      <= 1'b0;
            leds        <= '0;
            o_anim_busy <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_idx   <= phase_nxt;
            go_lvl      <= go_lvl_nxt;
            leds        <= leds_nxt;
            o_anim_busy <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_led_animator.sv
// tb_led_animator -- directed self-checking bench for led_animator with
// PHASE_CYCLES=4, N_BLINKS=3, GO_CYCLES=3.
module tb_led_animator;

    logic       clk;
    logic       rst_n;
    logic       restart_game;
    logic [2:0] user_guess;
    logic [2:0] mole_position;
    logic       user_right;
    logic       user_wrong;
    logic       game_over;
    logic [7:0] leds;
    logic       anim_busy;

    int n_checks;
    int n_fail;

    led_animator #(
        .POS_W(3), .STAT_W(2), .PHASE_CYCLES(4), .N_BLINKS(3), .GO_CYCLES(3)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_restart_game  (restart_game),
        .i_user_guess    (user_guess),
        .i_mole_position (mole_position),
        .i_user_right    (user_right),
        .i_user_wrong    (user_wrong),
        .i_game_over     (game_over),
        .leds            (leds),
        .o_anim_busy     (anim_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the 20 cycles of a blink sequence that began on the last edge,
    // then the return to IDLE. Guess=101, mole=010 throughout.
    task automatic check_blink(input string tag);
        logic [1:0] st;
        for (int i = 0; i < 20; i++) begin
            st = (((i / 4) % 2) == 0) ? 2'b11 : 2'b00;
            check({tag, "_leds"}, {24'd0, st, 6'b010_101}, {24'd0, leds});
            check({tag, "_busy"}, {31'd0, anim_busy}, 32'd1);
            step();
        end
        check({tag, "_end_leds"}, {24'd0, leds}, 32'h15);
        check({tag, "_end_busy"}, {31'd0, anim_busy}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        restart_game  = 1'b0;
        user_guess    = 3'b101;
        mole_position = 3'b010;
        user_right    = 1'b0;
        user_wrong    = 1'b0;
        game_over     = 1'b0;

        // Reset state, asserted without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_leds", {24'd0, leds}, 32'h00);
        check("rst_busy", {31'd0, anim_busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // IDLE follows positions with one cycle latency
        step();
        check("idle_leds", {24'd0, leds}, 32'h15);
        check("idle_busy", {31'd0, anim_busy}, 32'd0);
        user_guess = 3'b111; mole_position = 3'b000;
        step();
        check("idle_leds2", {24'd0, leds}, 32'h07);
        user_guess = 3'b000; mole_position = 3'b111;
        step();
        check("idle_leds3", {24'd0, leds}, 32'h38);
        user_guess = 3'b101; mole_position = 3'b010;
        step();
        check("idle_leds4", {24'd0, leds}, 32'h15);

        // Right pulse: full blink sequence
        user_right = 1'b1;
        step();
        user_right = 1'b0;
        check_blink("blink");

        // Wrong, then right six cycles later retriggers from phase 0
        user_wrong = 1'b1;
        step();
        user_wrong = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("solid_leds", {24'd0, leds}, 32'hD5);
            check("solid_busy", {31'd0, anim_busy}, 32'd1);
            if (i == 5) user_right = 1'b1;
            step();
            user_right = 1'b0;
        end
        check_blink("retrig");

        // Game over during BLINK; right/wrong are ignored afterwards
        user_right = 1'b1;
        step();
        user_right = 1'b0;
        step();
        step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        for (int i = 0; i < 18; i++) begin
            check("go_leds", {24'd0, leds}, ((((i / 3) % 2) == 0) ? 32'hFF : 32'h00));
            check("go_busy", {31'd0, anim_busy}, 32'd1);
            if (i == 7)  user_right = 1'b1;
            if (i == 10) user_wrong = 1'b1;
            step();
            user_right = 1'b0;
            user_wrong = 1'b0;
        end

        // Restart leaves GAME_OVER with leds dark for one cycle
        restart_game = 1'b1;
        step();
        restart_game = 1'b0;
        check("rs_go_leds", {24'd0, leds}, 32'h00);
        check("rs_go_busy", {31'd0, anim_busy}, 32'd0);
        step();
        check("rs_go_after", {24'd0, leds}, 32'h15);

        // Restart and right together: restart wins, no animation follows
        restart_game = 1'b1;
        user_right   = 1'b1;
        step();
        restart_game = 1'b0;
        user_right   = 1'b0;
        check("rs_right_leds", {24'd0, leds}, 32'h00);
        check("rs_right_busy", {31'd0, anim_busy}, 32'd0);
        for (int i = 0; i < 22; i++) begin
            step();
            check("rs_quiet_leds", {24'd0, leds}, 32'h15);
            check("rs_quiet_busy", {31'd0, anim_busy}, 32'd0);
        end

        // Game over outranks right in the same cycle
        game_over  = 1'b1;
        user_right = 1'b1;
        step();
        game_over  = 1'b0;
        user_right = 1'b0;
        check("go_prio_leds", {24'd0, leds}, 32'hFF);
        restart_game = 1'b1;
        step();
        restart_game = 1'b0;

        // Reset mid-SOLID clears outputs without a clock edge
        user_wrong = 1'b1;
        step();
        user_wrong = 1'b0;
        step();
        step();
        check("pre_rst_leds", {24'd0, leds}, 32'hD5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_leds", {24'd0, leds}, 32'h00);
        check("async_rst_busy", {31'd0, anim_busy}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            check("post_rst_leds", {24'd0, leds}, 32'h15);
            check("post_rst_busy", {31'd0, anim_busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
